// File: rtl/ultrasonic_echo_ranger.sv
// Ultrasonic range sensor timer: trigger pulse generation, echo width measurement, IRQ.
// Optional echo glitch filter enabled by defining ECHO_GLITCH_FILTER_EN.
module ultrasonic_echo_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1900000,
  parameter int COUNT_W        = 22
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        trig_out,
  input  logic        echo_in
);

  // state     | meaning
  // ----------+------------------------------------------------
  // IDLE      | waiting for START
  // TRIG      | trig_out high for TRIG_CYCLES
  // WAIT_RISE | waiting for echo rise, timeout running
  // MEASURE   | counting echo width, timeout running
  // HOLDOFF   | continuous-mode gap of PERIOD cycles
  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_HOLDOFF
  } state_t;

  localparam logic [COUNT_W-1:0] TRIG_LOAD = COUNT_W'(TRIG_CYCLES - 1);
  localparam logic [COUNT_W-1:0] TO_LAST   = COUNT_W'(TIMEOUT_CYCLES - 1);

  state_t state, state_next;

  logic               cont, irq_en, done, to_flag;
  logic [COUNT_W-1:0] width_q, period_q;
  logic [COUNT_W-1:0] trig_cnt, to_cnt, width_cnt, hold_cnt;

  logic wr, wr_ctrl, wr_status, wr_period;
  logic start, abort;
  logic ev_done, ev_to, to_hit;
  logic unused_wdata;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr & (address == 2'd0);
  assign wr_status = wr & (address == 2'd1);
  assign wr_period = wr & (address == 2'd3);
  assign start     = wr_ctrl & writedata[0];
  assign abort     = wr_ctrl & writedata[3];
  assign unused_wdata = ^writedata[31:COUNT_W];

  logic echo_m, echo_s, echo_acc, echo_acc_q, rise, fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
    end else begin
      echo_m <= echo_in;
      echo_s <= echo_m;
    end
  end

`ifdef ECHO_GLITCH_FILTER_EN
  // Accept a new level only once echo_s has held it for 4 consecutive cycles.
  logic [2:0] echo_hist;

  always_comb begin
    echo_acc = echo_acc_q;
    if (echo_s && (&echo_hist))
      echo_acc = 1'b1;
    else if (!echo_s && !(|echo_hist))
      echo_acc = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo_hist  <= '0;
      echo_acc_q <= 1'b0;
    end else begin
      echo_hist  <= {echo_hist[1:0], echo_s};
      echo_acc_q <= echo_acc;
    end
  end
`else
  assign echo_acc = echo_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) echo_acc_q <= 1'b0;
    else          echo_acc_q <= echo_s;
  end
`endif

  assign rise = echo_acc & ~echo_acc_q;
  assign fall = ~echo_acc & echo_acc_q;

  assign to_hit = (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_t after_meas;
    state_next = state;
    ev_done    = 1'b0;
    ev_to      = 1'b0;
    after_meas = S_IDLE;
    if (cont)
      after_meas = (period_q == '0) ? S_TRIG : S_HOLDOFF;
    case (state)
      S_IDLE:      if (start) state_next = S_TRIG;
      S_TRIG:      if (trig_cnt == '0) state_next = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (to_hit) begin
          ev_to      = 1'b1;
          state_next = after_meas;
        end else if (rise) begin
          state_next = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (fall) begin
          ev_done    = 1'b1;
          state_next = after_meas;
        end else if (to_hit) begin
          ev_to      = 1'b1;
          state_next = after_meas;
        end
      end
      S_HOLDOFF: begin
        if (!cont)
          state_next = S_IDLE;
        else if (hold_cnt == '0)
          state_next = S_TRIG;
      end
      default:     state_next = S_IDLE;
    endcase
    // Abort discards any event completing in the same cycle.
    if (abort) begin
      state_next = S_IDLE;
      ev_done    = 1'b0;
      ev_to      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_cnt  <= '0;
      to_cnt    <= '0;
      width_cnt <= '0;
      hold_cnt  <= '0;
    end else if (abort) begin
      trig_cnt  <= '0;
      to_cnt    <= '0;
      width_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      if (state != S_TRIG && state_next == S_TRIG)
        trig_cnt <= TRIG_LOAD;
      else if (state == S_TRIG && trig_cnt != '0)
        trig_cnt <= trig_cnt - 1'b1;

      if (state == S_TRIG)
        to_cnt <= '0;
      else if ((state == S_WAIT_RISE || state == S_MEASURE) && !to_hit)
        to_cnt <= to_cnt + 1'b1;

      if (state == S_WAIT_RISE)
        width_cnt <= COUNT_W'(1);
      else if (state == S_MEASURE && width_cnt != '1)
        width_cnt <= width_cnt + 1'b1;

      if (state != S_HOLDOFF && state_next == S_HOLDOFF)
        hold_cnt <= period_q - 1'b1;
      else if (state == S_HOLDOFF && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cont     <= 1'b0;
      irq_en   <= 1'b0;
      period_q <= '0;
      width_q  <= '0;
      done     <= 1'b0;
      to_flag  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        cont   <= writedata[1];
        irq_en <= writedata[2];
      end
      if (wr_period)
        period_q <= writedata[COUNT_W-1:0];

      if (ev_to)
        width_q <= '1;
      else if (ev_done)
        width_q <= width_cnt;

      // A flag being set wins over a simultaneous write-1-clear.
      if (ev_done)
        done <= 1'b1;
      else if (wr_status && writedata[1])
        done <= 1'b0;

      if (ev_to)
        to_flag <= 1'b1;
      else if (wr_status && writedata[2])
        to_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= {28'd0, 1'b0, irq_en, cont, 1'b0};
        2'd1:    readdata <= {29'd0, to_flag, done, (state != S_IDLE)};
        2'd2:    readdata <= 32'(width_q);
        default: readdata <= 32'(period_q);
      endcase
    end
  end

  assign trig_out = (state == S_TRIG);
  assign irq      = irq_en & (done | to_flag);

endmodule
